controle_execucao: RTL and testbench

Execution sequencer for the single-cycle processor: generates the one-cycle commit enable (`cpu_en`) that advances PC, register file and memory writes. It stalls the processor on HD accesses until the disk controller acknowledges and on WAIT (syscall input) until the operator presses the confirm button. It latches HALT and provides a single-step mode for board debugging. It sits between the processor's control outputs (HALT, WAIT, HD select) and the processor/memory clock-enable inputs.

---
 rtl/controle_execucao.sv | 135 +++++++++++++
 tb/tb_controle_execucao.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_execucao.sv
// Execution sequencer: generates the one-cycle commit enable for the single-cycle CPU,
// stalling on HD accesses and operator WAITs, latching HALT, with an optional single-step mode.
module controle_execucao #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HD_TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HALT,
    input  logic        WAIT,
    input  logic        hd_acc,
    input  logic        hd_ready,
    input  logic        btn_continue,
    input  logic        step_mode,
    output logic        cpu_en,
    output logic        hd_start,
    output logic        halted,
    output logic        hd_err,
    output logic [2:0]  estado,
    output logic [31:0] instr_count
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TOW = $clog2(HD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        HD_WAIT = 3'd1,
        IO_WAIT = 3'd2,
        HALTED  = 3'd3,
        HD_ERR  = 3'd4
    } state_t;

    state_t         state;
    state_t         next_state;
    logic           sync1;
    logic           sync2;
    logic           db_level;
    logic [DBW-1:0] db_cnt;
    logic [TOW-1:0] to_cnt;
    logic           btn_press;
    logic           start_next;
    logic           db_last;
    logic           to_last;

    assign db_last   = (db_cnt == DBW'(DEBOUNCE_CYCLES - 1));
    // Press fires on the sample that completes the debounce run, so commit lands on the toggle edge.
    assign btn_press = sync2 & ~db_level & db_last;
    assign to_last   = (to_cnt == TOW'(HD_TIMEOUT - 1));
    assign estado    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1 <= btn_continue;
            sync2 <= sync1;
            if (sync2 != db_level) begin
                if (db_last) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        cpu_en     = 1'b0;
        start_next = 1'b0;
        case (state)
            RUN: begin
                if (HALT) begin
                    next_state = HALTED;
                end else if (hd_acc) begin
                    next_state = HD_WAIT;
                    start_next = 1'b1;
                end else if (WAIT) begin
                    next_state = IO_WAIT;
                end else begin
                    cpu_en = step_mode ? btn_press : 1'b1;
                end
            end
            HD_WAIT: begin
                if (hd_ready) begin
                    cpu_en     = 1'b1;
                    next_state = RUN;
                end else if (to_last) begin
                    next_state = HD_ERR;
                end
            end
            IO_WAIT: begin
                if (btn_press) begin
                    cpu_en     = 1'b1;
                    next_state = RUN;
                end
            end
            HALTED:  next_state = HALTED;
            HD_ERR:  next_state = HD_ERR;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            hd_start    <= 1'b0;
            halted      <= 1'b0;
            hd_err      <= 1'b0;
            to_cnt      <= '0;
            instr_count <= '0;
        end else begin
            state    <= next_state;
            hd_start <= start_next;
            halted   <= (next_state == HALTED);
            hd_err   <= (next_state == HD_ERR);
            if (state == HD_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (cpu_en) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_controle_execucao.sv
// Directed bench for controle_execucao: commit scoreboard plus state/flag checks per scenario.
module tb_controle_execucao;

    localparam int unsigned DEB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        HALT;
    logic        WAIT;
    logic        hd_acc;
    logic        hd_ready;
    logic        btn_continue;
    logic        step_mode;
    logic        cpu_en;
    logic        hd_start;
    logic        halted;
    logic        hd_err;
    logic [2:0]  estado;
    logic [31:0] instr_count;

    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    int          commits = 0;
    int          last_commit_cyc = 0;
    int          c0;
    int          t0;
    logic [31:0] model_count = '0;
    logic [31:0] exp_q[$];

    controle_execucao #(.DEBOUNCE_CYCLES(DEB), .HD_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .HALT(HALT), .WAIT(WAIT), .hd_acc(hd_acc),
        .hd_ready(hd_ready), .btn_continue(btn_continue), .step_mode(step_mode),
        .cpu_en(cpu_en), .hd_start(hd_start), .halted(halted), .hd_err(hd_err),
        .estado(estado), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_commit();
        model_count = model_count + 32'd1;
        exp_q.push_back(model_count);
    endtask

    // One clock: sample cpu_en mid-cycle, then settle after the edge and score any commit.
    task automatic tick();
        logic en;
        logic rst;
        @(negedge clk);
        en  = cpu_en;
        rst = reset;
        @(posedge clk);
        cyc++;
        #1;
        if (en && !rst) begin
            commits++;
            last_commit_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_commit", {31'b0, en}, 32'd0);
            end else begin
                check("commit_count", instr_count, exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; HALT = 1'b0; WAIT = 1'b0; hd_acc = 1'b0; hd_ready = 1'b0;
        btn_continue = 1'b0; step_mode = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_count = '0;
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_estado", 32'(estado), 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_hd_err", 32'(hd_err), 32'd0);
        check("rst_hd_start", 32'(hd_start), 32'd0);

        // Free-run: ten normal instructions
        step_mode = 1'b0;
        c0 = commits;
        for (int i = 0; i < 10; i++) begin
            expect_commit();
            tick();
        end
        step_mode = 1'b1;
        check("free_commits", 32'(commits - c0), 32'd10);
        check("free_count", instr_count, 32'd10);
        check("free_estado", 32'(estado), 32'd0);

        // hd_ready outside HD_WAIT is ignored
        hd_ready = 1'b1;
        tick();
        hd_ready = 1'b0;

        // HD access with hd_ready five cycles after hd_start
        hd_acc = 1'b1;
        tick();
        check("hd_start_pulse", 32'(hd_start), 32'd1);
        check("hd_estado", 32'(estado), 32'd1);
        tick();
        check("hd_start_single", 32'(hd_start), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("hd_no_early_commit", instr_count, 32'd10);
        hd_ready = 1'b1;
        expect_commit();
        tick();
        hd_acc = 1'b0; hd_ready = 1'b0;
        check("hd_count", instr_count, 32'd11);
        check("hd_back_run", 32'(estado), 32'd0);
        check("hd_pending", 32'(exp_q.size()), 32'd0);

        // HD timeout
        hd_acc = 1'b1;
        tick();
        hd_acc = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        check("to_still_wait", 32'(estado), 32'd1);
        check("to_no_err_yet", 32'(hd_err), 32'd0);
        tick();
        check("to_estado", 32'(estado), 32'd4);
        check("to_hd_err", 32'(hd_err), 32'd1);
        hd_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        hd_ready = 1'b0;
        check("to_sticky", 32'(estado), 32'd4);
        check("to_count", instr_count, 32'd11);
        do_reset();
        check("to_rst_estado", 32'(estado), 32'd0);
        check("to_rst_err", 32'(hd_err), 32'd0);

        // Reset coinciding with an HD access issues no hd_start
        hd_acc = 1'b1; reset = 1'b1;
        tick();
        hd_acc = 1'b0; reset = 1'b0;
        check("rst_hd_no_start", 32'(hd_start), 32'd0);
        check("rst_hd_estado", 32'(estado), 32'd0);

        // Button debounce in IO_WAIT
        WAIT = 1'b1;
        tick();
        check("io_estado", 32'(estado), 32'd2);
        for (int i = 0; i < 12; i++) begin
            btn_continue = ((i / 3) % 2 == 0);
            tick();
        end
        btn_continue = 1'b1;
        t0 = cyc;
        c0 = commits;
        expect_commit();
        for (int i = 0; i < 40 && commits == c0; i++) tick();
        WAIT = 1'b0;
        check("deb_latency", 32'(last_commit_cyc - t0), 32'(DEB + 2));
        for (int i = 0; i < 30; i++) tick();
        check("deb_single", 32'(commits - c0), 32'd1);
        check("deb_count", instr_count, 32'd1);
        check("deb_run", 32'(estado), 32'd0);
        btn_continue = 1'b0;
        for (int i = 0; i < 25; i++) tick();

        // Step mode: three clean presses
        c0 = commits;
        for (int p = 0; p < 3; p++) begin
            btn_continue = 1'b1;
            expect_commit();
            for (int i = 0; i < 25; i++) tick();
            btn_continue = 1'b0;
            for (int i = 0; i < 25; i++) tick();
        end
        check("step_commits", 32'(commits - c0), 32'd3);
        check("step_count", instr_count, 32'd4);
        check("step_pending", 32'(exp_q.size()), 32'd0);

        // Counter wrap: preload all-ones while stalled in IO_WAIT
        WAIT = 1'b1;
        tick();
        force dut.instr_count = 32'hFFFF_FFFF;
        tick();
        release dut.instr_count;
        model_count = 32'hFFFF_FFFF;
        btn_continue = 1'b1;
        c0 = commits;
        expect_commit();
        for (int i = 0; i < 30 && commits == c0; i++) tick();
        check("wrap_count", instr_count, 32'd0);
        check("wrap_pending", 32'(exp_q.size()), 32'd0);
        btn_continue = 1'b0;
        WAIT = 1'b0;
        for (int i = 0; i < 25; i++) tick();

        // HALT has priority over hd_acc and WAIT
        do_reset();
        HALT = 1'b1; WAIT = 1'b1; hd_acc = 1'b1;
        tick();
        check("halt_estado", 32'(estado), 32'd3);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_no_start", 32'(hd_start), 32'd0);
        HALT = 1'b0; WAIT = 1'b0; hd_acc = 1'b0; step_mode = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("halt_sticky", 32'(estado), 32'd3);
        check("halt_count", instr_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
